// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter over N requesters with a registered one-hot grant.
// A rotating priority pointer guarantees each active requester is served within N-1 cycles.
module round_robin_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_sigs,
  output logic [N-1:0] grant_sigs
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(N - 1);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    grant_q, grant_d;

  always_comb begin
    logic            found;
    logic [PtrW-1:0] rem;
    logic [PtrW-1:0] idx;
    logic [PtrW-1:0] step;
    grant_d = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    // Steps left before the search wraps past N-1; keeps index math inside PtrW bits.
    rem     = LastIdx - ptr_q;
    idx     = '0;
    step    = '0;
    for (int unsigned off = 0; off < N; off++) begin
      step = PtrW'(off);
      if (step > rem) begin
        idx = step - rem - PtrW'(1);
      end else begin
        idx = ptr_q + step;
      end
      if (!found && req_sigs[idx]) begin
        found        = 1'b1;
        grant_d[idx] = 1'b1;
        ptr_d        = (idx == LastIdx) ? '0 : idx + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_sigs = grant_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_round_robin_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_sigs;
  logic [N-1:0] grant_sigs;

  int n_vec;
  int n_err;

  // Reference model state: priority pointer and expected grant.
  int           ptr_m;
  logic [N-1:0] exp_g;

  round_robin_arbiter #(
    .N(N)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_sigs  (req_sigs),
    .grant_sigs(grant_sigs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Drive inputs mid-cycle, clock once, advance the model, sample shortly after the edge.
  task automatic apply(input logic rst_v, input logic [N-1:0] req_v);
    @(negedge clk);
    rst      = rst_v;
    req_sigs = req_v;
    @(posedge clk);
    exp_g = '0;
    if (!rst_v) begin
      ptr_m = 0;
    end else begin
      for (int off = 0; off < N; off++) begin
        int k;
        k = (ptr_m + off) % N;
        if (req_v[k]) begin
          exp_g[k] = 1'b1;
          ptr_m    = (k + 1) % N;
          break;
        end
      end
    end
    #1;
    check_eq("model", grant_sigs, exp_g);
    check_eq("onehot0", {{(N-1){1'b0}}, $onehot0(grant_sigs)}, {{(N-1){1'b0}}, 1'b1});
  endtask

  task automatic apply_lit(input string tag, input logic rst_v, input logic [N-1:0] req_v,
                           input logic [N-1:0] lit);
    apply(rst_v, req_v);
    check_eq(tag, grant_sigs, lit);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    ptr_m    = 0;
    exp_g    = '0;
    rst      = 1'b0;
    req_sigs = '0;

    // Reset held with requests present
    apply_lit("rst_hold0", 1'b0, 4'b1011, 4'b0000);
    apply_lit("rst_hold1", 1'b0, 4'b1011, 4'b0000);

    // Release reset with 1011 held
    apply_lit("rel_0", 1'b1, 4'b1011, 4'b0001);
    apply_lit("rel_1", 1'b1, 4'b1011, 4'b0010);
    apply_lit("rel_2", 1'b1, 4'b1011, 4'b1000);
    apply_lit("rel_3", 1'b1, 4'b1011, 4'b0001);

    // All requesting: full rotation
    apply_lit("all_rst", 1'b0, 4'b1111, 4'b0000);
    apply_lit("all_0", 1'b1, 4'b1111, 4'b0001);
    apply_lit("all_1", 1'b1, 4'b1111, 4'b0010);
    apply_lit("all_2", 1'b1, 4'b1111, 4'b0100);
    apply_lit("all_3", 1'b1, 4'b1111, 4'b1000);
    apply_lit("all_4", 1'b1, 4'b1111, 4'b0001);

    // Single persistent requester, then pointer wrap
    apply_lit("solo_rst", 1'b0, 4'b0000, 4'b0000);
    apply_lit("solo_0", 1'b1, 4'b1000, 4'b1000);
    apply_lit("solo_1", 1'b1, 4'b1000, 4'b1000);
    apply_lit("solo_2", 1'b1, 4'b1000, 4'b1000);
    apply_lit("wrap_0", 1'b1, 4'b1001, 4'b0001);
    apply_lit("wrap_1", 1'b1, 4'b1001, 4'b1000);

    // Idle cycles keep the pointer
    apply_lit("idle_rst", 1'b0, 4'b0000, 4'b0000);
    apply_lit("idle_a", 1'b1, 4'b1100, 4'b0100);
    apply_lit("idle_z0", 1'b1, 4'b0000, 4'b0000);
    apply_lit("idle_z1", 1'b1, 4'b0000, 4'b0000);
    apply_lit("idle_b", 1'b1, 4'b1100, 4'b1000);

    // Reset mid-rotation discards history
    apply_lit("mid_rst0", 1'b0, 4'b1111, 4'b0000);
    apply_lit("mid_0", 1'b1, 4'b1111, 4'b0001);
    apply_lit("mid_1", 1'b1, 4'b1111, 4'b0010);
    apply_lit("mid_rst1", 1'b0, 4'b1111, 4'b0000);
    apply_lit("mid_2", 1'b1, 4'b1111, 4'b0001);

    // Randomized traffic with occasional resets and between-edge request glitches
    for (int i = 0; i < 400; i++) begin
      logic         r;
      logic [N-1:0] q;
      r = ($urandom_range(0, 24) != 0);
      q = N'($urandom);
      apply(r, q);
      // Glitch after the edge; overwritten before the next edge and must not matter.
      req_sigs = N'($urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters; all behaviour below SHALL hold for N >= 2, and verification SHALL use N=4.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on the rising edge of clk.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; reset SHALL be synchronous and active-low.
REQ-004 The block SHALL have port req_sigs, input, N bits; bit i high SHALL mean requester i requests access.
REQ-005 The block SHALL have port grant_sigs, output, N bits, registered; bit i high SHALL mean requester i holds the grant for the current cycle.

Function
REQ-006 grant_sigs SHALL be one-hot or all-zero at all times, and no two bits SHALL ever be high together.
REQ-007 The block SHALL keep an internal priority pointer ptr in the range 0..N-1; ptr names the requester with highest priority at the next arbitration.
REQ-008 On every rising edge with rst high, the block SHALL search the req_sigs sampled at that edge, starting from index ptr, upward with wrap-around (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
REQ-009 The first index k found with req_sigs[k]=1 SHALL be granted: grant_sigs becomes only bit k set, effective one cycle after the requesting edge, so latency from request to grant is 1 clock.
REQ-010 After granting k, ptr SHALL become (k+1) mod N, with wrap from N-1 to 0.
REQ-011 If req_sigs is all-zero at an edge, grant_sigs SHALL become all-zero and ptr SHALL be unchanged.
REQ-012 Grants SHALL NOT be held across cycles: arbitration SHALL be re-run every cycle, with no lock or handshake.
REQ-013 A requester that drops its request SHALL lose the grant at the next edge.
REQ-014 A single persistent requester SHALL be granted every cycle.
REQ-015 With all N requesters continuously asserted, grants SHALL rotate 0,1,...,N-1,0; each requester SHALL wait at most N-1 cycles between grants (starvation-free).
REQ-016 The grant SHALL depend only on ptr and the current req_sigs; a change in req_sigs between edges SHALL have no effect until the next edge.

Reset
REQ-017 When rst is low at a rising edge, grant_sigs SHALL become all-zero and ptr SHALL become 0, regardless of req_sigs.
REQ-018 While rst is held low, grant_sigs SHALL remain all-zero.
REQ-019 Reset asserted mid-operation SHALL discard any rotation history.
REQ-020 At the first edge with rst high, arbitration SHALL begin from index 0.
REQ-021 Before the first reset, grant_sigs SHALL be treated as undefined.

Verification
REQ-022 Hold rst=0 with req_sigs=1011 for 2 cycles -> grant_sigs=0000 throughout.
REQ-023 Release reset with req_sigs=1011 held -> grants on successive cycles are 0001, 0010, 1000, 0001.
REQ-024 After reset, req_sigs=1111 held -> grants are 0001, 0010, 0100, 1000, 0001.
REQ-025 After reset:
- req_sigs=1000 held -> 1000 every cycle.
- Then req_sigs=1001 -> next grant is 0001 (ptr wrapped to 0), then 1000.
REQ-026 After reset:
- req_sigs=1100 -> 0100.
- Then req_sigs=0000 for 2 cycles -> 0000, 0000.
- Then req_sigs=1100 -> 1000 (ptr preserved at 3).
REQ-027 Mid-rotation with req_sigs=1111 (last grant 0010):
- rst=0 for 1 edge -> 0000.
- Then rst=1 -> 0001.
